act_buf_filler: RTL

Upstream fill stage for the activation buffer. It accepts a narrow activation stream from the DMA/controller side and packs ACT_WIDTH/IN_WIDTH consecutive words into one full-width buffer line. It writes each line into the on-chip activation buffer at consecutive addresses from a programmed base. The lines it writes are the tiles later read out by the activation dispatcher and sent to the PE array.

---
 rtl/act_buf_filler_if.sv | 28 ++
 rtl/act_buf_filler.sv | 134 +++++++++++++
 2 files changed

// File: rtl/act_buf_filler_if.sv
// Signal bundle for the activation buffer fill stage: control, input stream and buffer write port.
interface act_buf_filler_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned ACT_WIDTH  = 1024,
  parameter int unsigned IN_WIDTH   = 64
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] num_tiles;
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   in_data;
  logic                  buf_wr_en;
  logic [ADDR_WIDTH-1:0] buf_wr_addr;
  logic [ACT_WIDTH-1:0]  buf_wr_data;
  logic                  busy;
  logic                  done;

  modport master (
    output start, base_addr, num_tiles, in_valid, in_data,
    input  in_ready, buf_wr_en, buf_wr_addr, buf_wr_data, busy, done
  );

  modport slave (
    input  start, base_addr, num_tiles, in_valid, in_data,
    output in_ready, buf_wr_en, buf_wr_addr, buf_wr_data, busy, done
  );
endinterface

// File: rtl/act_buf_filler.sv
// Packs ACT_WIDTH/IN_WIDTH narrow stream words into full activation lines and writes them
// to consecutive buffer addresses starting at a programmed base.
module act_buf_filler #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned ACT_WIDTH  = 1024,
  parameter int unsigned IN_WIDTH   = 64
) (
  input logic              clk,
  input logic              rst_n,
  act_buf_filler_if.slave  bus
);
  localparam int unsigned WORDS = ACT_WIDTH / IN_WIDTH;
  localparam int unsigned WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WCW-1:0] LastWord = WCW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

  state_e                state_q, state_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH:0]   tile_cnt_q, tile_cnt_d;
  logic [ADDR_WIDTH:0]   tile_next;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] num_q, num_d;
  logic [ACT_WIDTH-1:0]  line_q, line_d;
  logic                  in_ready_q, in_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ACT_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Extra bit so num_tiles = 2^ADDR_WIDTH-1 terminates without wrapping the compare.
  assign tile_next = tile_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    tile_cnt_d = tile_cnt_q;
    base_d     = base_q;
    num_d      = num_q;
    line_d     = line_q;
    in_ready_d = in_ready_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.num_tiles != '0) begin
            base_d     = bus.base_addr;
            num_d      = bus.num_tiles;
            word_cnt_d = '0;
            tile_cnt_d = '0;
            busy_d     = 1'b1;
            in_ready_d = 1'b1;
            state_d    = StFill;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StFill: begin
        if (bus.in_valid && in_ready_q) begin
          for (int k = 0; k < WORDS; k++) begin
            if (word_cnt_q == WCW'(k)) line_d[k*IN_WIDTH +: IN_WIDTH] = bus.in_data;
          end
          if (word_cnt_q == LastWord) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = base_q + tile_cnt_q[ADDR_WIDTH-1:0];
            wr_data_d  = line_d;
            in_ready_d = 1'b0;
            state_d    = StWrite;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      StWrite: begin
        word_cnt_d = '0;
        if (tile_next < {1'b0, num_q}) begin
          tile_cnt_d = tile_next;
          in_ready_d = 1'b1;
          state_d    = StFill;
        end else begin
          busy_d     = 1'b0;
          in_ready_d = 1'b0;
          done_d     = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      tile_cnt_q <= '0;
      base_q     <= '0;
      num_q      <= '0;
      line_q     <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      tile_cnt_q <= tile_cnt_d;
      base_q     <= base_d;
      num_q      <= num_d;
      line_q     <= line_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.buf_wr_en   = wr_en_q;
  assign bus.buf_wr_addr = wr_addr_q;
  assign bus.buf_wr_data = wr_data_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule
